cv_ctrl_if: RTL and testbench



---
 rtl/cv_ctrl_if.sv | 106 ++++++++++
 tb/tb_cv_ctrl_if.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_ctrl_if.sv
// cv_ctrl_if: ColecoVision / SG-1000 controller port stage.
// Mode flip-flop, pad synchronisers, CPU read mux and spinner interrupt.
`default_nettype none

module cv_ctrl_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       sg1000_i,
  input  logic [1:0] a_i,
  input  logic       ctrl_en_key_n_i,
  input  logic       ctrl_en_joy_n_i,
  input  logic       ctrl_r_n_i,
  input  logic [4:0] joy_p1_i,
  input  logic [4:0] joy_p2_i,
  input  logic [4:0] key_p1_i,
  input  logic [4:0] key_p2_i,
  input  logic [1:0] spin_p1_i,
  input  logic [1:0] spin_p2_i,
  output logic [7:0] d_o,
  output logic       int_n_o
);

  localparam int PAD_W = 24;

  logic [PAD_W-1:0] sync_q [SYNC_STAGES];
  logic [PAD_W-1:0] synced;
  logic [4:0]       joy1, joy2, key1, key2;
  logic [1:0]       spin_a, spin_b;
  logic [1:0]       spin_prev, spin_dir, pend, rise, clr;
  logic             mode, rd_prev, rd_fall, int_n_q;
  logic             p;
  logic [4:0]       jp, kp;
  logic [7:0]       rd_byte;

  // Packed pad vector: {spin_p2, spin_p1, key_p2, key_p1, joy_p2, joy_p1}
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {spin_p2_i, spin_p1_i, key_p2_i, key_p1_i, joy_p2_i, joy_p1_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign joy1   = synced[4:0];
  assign joy2   = synced[9:5];
  assign key1   = synced[14:10];
  assign key2   = synced[19:15];
  assign spin_a = {synced[22], synced[20]};
  assign spin_b = {synced[23], synced[21]};

  assign rise    = spin_a & ~spin_prev;
  assign rd_fall = ~ctrl_r_n_i & rd_prev;
  assign clr     = (rd_fall && mode) ? (a_i[1] ? 2'b10 : 2'b01) : 2'b00;

  // A spinner edge on the clearing clock wins over the clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mode      <= 1'b0;
      spin_prev <= 2'b00;
      spin_dir  <= 2'b00;
      pend      <= 2'b00;
      rd_prev   <= 1'b1;
      int_n_q   <= 1'b1;
    end else begin
      if (!sg1000_i) begin
        if (!ctrl_en_joy_n_i)      mode <= 1'b1;
        else if (!ctrl_en_key_n_i) mode <= 1'b0;
      end
      spin_prev <= spin_a;
      spin_dir  <= (spin_dir & ~rise) | (spin_b & rise);
      pend      <= sg1000_i ? 2'b00 : ((pend & ~clr) | rise);
      rd_prev   <= ctrl_r_n_i;
      int_n_q   <= sg1000_i | ~(|pend);
    end
  end

  assign p  = a_i[1];
  assign jp = p ? joy2 : joy1;
  assign kp = p ? key2 : key1;

  always_comb begin
    rd_byte = 8'hFF;
    if (sg1000_i) begin
      if (!a_i[0])
        rd_byte = {~joy2[2], ~joy2[0], ~key1[4], ~joy1[4],
                   ~joy1[1], ~joy1[3], ~joy1[2], ~joy1[0]};
      else
        rd_byte = {4'hF, ~key2[4], ~joy2[4], ~joy2[1], ~joy2[3]};
    end else if (mode) begin
      rd_byte = {1'b1, ~jp[4], 1'b1, ~spin_dir[p], ~jp[3], ~jp[2], ~jp[1], ~jp[0]};
    end else begin
      rd_byte = {1'b1, ~kp[4], 2'b11, kp[3:0]};
    end
  end

  // Reset gates the bus immediately, even mid-read.
  assign d_o     = (!reset_n_i || ctrl_r_n_i) ? 8'hFF : rd_byte;
  assign int_n_o = int_n_q;

endmodule

`default_nettype wire

// File: tb/tb_cv_ctrl_if.sv
// tb_cv_ctrl_if: scoreboard bench for the controller port stage.
`default_nettype none

module tb_cv_ctrl_if;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset_n, sg1000, ctrl_en_key_n, ctrl_en_joy_n, ctrl_r_n;
  logic [1:0] a, spin_p1, spin_p2;
  logic [4:0] joy_p1, joy_p2, key_p1, key_p2;
  logic [7:0] d;
  logic       int_n;

  logic [7:0] exp_q [$];
  logic [7:0] got8, e8;
  int         checks = 0;
  int         passed = 0;

  cv_ctrl_if #(.SYNC_STAGES(S)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .sg1000_i(sg1000), .a_i(a),
    .ctrl_en_key_n_i(ctrl_en_key_n), .ctrl_en_joy_n_i(ctrl_en_joy_n),
    .ctrl_r_n_i(ctrl_r_n), .joy_p1_i(joy_p1), .joy_p2_i(joy_p2),
    .key_p1_i(key_p1), .key_p2_i(key_p2), .spin_p1_i(spin_p1),
    .spin_p2_i(spin_p2), .d_o(d), .int_n_o(int_n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  function automatic logic [7:0] joy_model(input logic [4:0] j, input logic sd);
    logic [7:0] b;
    b = 8'hFF;
    if (j[0]) b[0] = 1'b0;
    if (j[1]) b[1] = 1'b0;
    if (j[2]) b[2] = 1'b0;
    if (j[3]) b[3] = 1'b0;
    if (sd)   b[4] = 1'b0;
    if (j[4]) b[6] = 1'b0;
    return b;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic begin_read(input logic [1:0] addr, input logic [7:0] expv);
    exp_q.push_back(expv);
    a = addr;
    ctrl_r_n = 1'b0;
    #1;
  endtask

  task automatic end_read();
    @(negedge clk);
    ctrl_r_n = 1'b1;
  endtask

  task automatic pulse_joy();
    ctrl_en_joy_n = 1'b0;
    tick(1);
    ctrl_en_joy_n = 1'b1;
  endtask

  task automatic pulse_key();
    ctrl_en_key_n = 1'b0;
    tick(1);
    ctrl_en_key_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sg1000 = 1'b0; a = 2'b00;
    ctrl_en_key_n = 1'b1; ctrl_en_joy_n = 1'b1; ctrl_r_n = 1'b1;
    joy_p1 = '0; joy_p2 = '0; key_p1 = 5'b0_1111; key_p2 = 5'b0_1111;
    spin_p1 = '0; spin_p2 = '0;
    tick(3);
    checks++; if (d !== 8'hFF) $display("FAIL reset_d: d_o=%h expected ff", d); else passed++;
    checks++; if (int_n !== 1'b1) $display("FAIL reset_int: int_n=%b expected 1", int_n); else passed++;
    begin_read(2'd0, 8'hFF);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL read_in_reset: d_o=%h expected %h", got8, e8); else passed++;
    ctrl_r_n = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(S + 1);
    begin_read(2'd0, 8'hFF);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL idle_keypad: d_o=%h expected %h", got8, e8); else passed++;
    end_read();
    checks++; if (int_n !== 1'b1) $display("FAIL idle_int: int_n=%b expected 1", int_n); else passed++;
    tick(1);
  endtask

  task automatic test_joystick();
    logic [4:0] pat;
    pulse_joy();
    joy_p1 = 5'b10001;
    tick(S + 1);
    begin_read(2'd0, 8'hBE);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL joy_p1: d_o=%h expected %h", got8, e8); else passed++;
    end_read(); tick(1);
    begin_read(2'd2, 8'hFF);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL joy_p2_idle: d_o=%h expected %h", got8, e8); else passed++;
    end_read(); tick(1);
    for (int i = 0; i < 4; i++) begin
      pat = 5'($urandom_range(0, 31));
      joy_p2 = pat;
      tick(S + 1);
      begin_read(2'd2, joy_model(pat, 1'b0));
      got8 = d; e8 = exp_q.pop_front();
      checks++; if (got8 !== e8) $display("FAIL joy_p2_pat%0d: d_o=%h expected %h", i, got8, e8); else passed++;
      end_read(); tick(1);
    end
    joy_p2 = '0;
    tick(S + 1);
  endtask

  task automatic test_mode_priority();
    pulse_key();
    ctrl_en_key_n = 1'b0; ctrl_en_joy_n = 1'b0;
    tick(1);
    ctrl_en_key_n = 1'b1; ctrl_en_joy_n = 1'b1;
    begin_read(2'd0, 8'hBE);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL both_strobes: d_o=%h expected %h", got8, e8); else passed++;
    end_read(); tick(1);
    pulse_key();
    key_p2 = 5'b1_0101;
    tick(S + 1);
    begin_read(2'd2, 8'hB5);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL keypad_p2: d_o=%h expected %h", got8, e8); else passed++;
    end_read(); tick(1);
    key_p2 = 5'b0_1111;
  endtask

  task automatic test_spinner();
    pulse_joy();
    joy_p1 = '0;
    spin_p1 = 2'b10;
    tick(S + 2);
    spin_p1 = 2'b11;
    tick(S + 1);
    checks++; if (int_n !== 1'b1) $display("FAIL spin_int_early: int_n=%b expected 1", int_n); else passed++;
    tick(1);
    checks++; if (int_n !== 1'b0) $display("FAIL spin_int_set: int_n=%b expected 0", int_n); else passed++;
    pulse_key();
    begin_read(2'd0, 8'hFF);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL spin_keypad_rd: d_o=%h expected %h", got8, e8); else passed++;
    end_read(); tick(2);
    checks++; if (int_n !== 1'b0) $display("FAIL keypad_no_clear: int_n=%b expected 0", int_n); else passed++;
    pulse_joy();
    begin_read(2'd0, 8'hEF);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL spin_dir_bit: d_o=%h expected %h", got8, e8); else passed++;
    end_read();
    checks++; if (int_n !== 1'b0) $display("FAIL clear_lag: int_n=%b expected 0", int_n); else passed++;
    tick(1);
    checks++; if (int_n !== 1'b1) $display("FAIL clear_int: int_n=%b expected 1", int_n); else passed++;
  endtask

  task automatic test_set_clear_same_cycle();
    spin_p1 = 2'b10;
    tick(S + 2);
    spin_p1 = 2'b11;
    tick(2);
    begin_read(2'd0, 8'hEF);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL same_cycle_rd: d_o=%h expected %h", got8, e8); else passed++;
    end_read();
    checks++; if (int_n !== 1'b1) $display("FAIL same_cycle_pre: int_n=%b expected 1", int_n); else passed++;
    tick(1);
    checks++; if (int_n !== 1'b0) $display("FAIL set_wins: int_n=%b expected 0", int_n); else passed++;
    tick(3);
    checks++; if (int_n !== 1'b0) $display("FAIL set_held: int_n=%b expected 0", int_n); else passed++;
  endtask

  task automatic test_reset_mid_read();
    joy_p1 = 5'b00001;
    spin_p1 = 2'b00;
    a = 2'd0;
    ctrl_r_n = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (d !== 8'hFF) $display("FAIL midread_rst_d: d_o=%h expected ff", d); else passed++;
    checks++; if (int_n !== 1'b1) $display("FAIL midread_rst_int: int_n=%b expected 1", int_n); else passed++;
    @(negedge clk);
    ctrl_r_n = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(S + 2);
    checks++; if (int_n !== 1'b1) $display("FAIL post_rst_int: int_n=%b expected 1", int_n); else passed++;
    begin_read(2'd0, 8'hFF);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL post_rst_mode: d_o=%h expected %h", got8, e8); else passed++;
    end_read(); tick(1);
  endtask

  task automatic test_sg1000();
    sg1000 = 1'b1;
    joy_p1 = 5'b00001; joy_p2 = 5'b00100;
    tick(S + 1);
    begin_read(2'd0, 8'h7E);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL sg_port_dc: d_o=%h expected %h", got8, e8); else passed++;
    end_read(); tick(1);
    joy_p1 = 5'b00000; joy_p2 = 5'b10000;
    tick(S + 1);
    begin_read(2'd1, 8'hFB);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL sg_port_dd: d_o=%h expected %h", got8, e8); else passed++;
    end_read(); tick(1);
    joy_p2 = '0;
    for (int i = 0; i < 3; i++) begin
      spin_p1 = 2'b01; spin_p2 = 2'b11;
      tick(S + 3);
      checks++; if (int_n !== 1'b1) $display("FAIL sg_spin_int%0d: int_n=%b expected 1", i, int_n); else passed++;
      spin_p1 = 2'b00; spin_p2 = 2'b00;
      tick(S + 1);
    end
    pulse_joy();
    key_p1 = 5'b0_0011;
    tick(S + 1);
    sg1000 = 1'b0;
    begin_read(2'd0, 8'hF3);
    got8 = d; e8 = exp_q.pop_front();
    checks++; if (got8 !== e8) $display("FAIL sg_mode_ignored: d_o=%h expected %h", got8, e8); else passed++;
    end_read(); tick(2);
    checks++; if (int_n !== 1'b1) $display("FAIL sg_pend_held: int_n=%b expected 1", int_n); else passed++;
  endtask

  initial begin
    test_reset();
    test_joystick();
    test_mode_priority();
    test_spinner();
    test_set_clear_same_cycle();
    test_reset_mid_read();
    test_sg1000();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
